uncached_axi_bridge: RTL and testbench
======================================

Name: uncached_axi_bridge

Overview:
- Downstream consumer of the uncached ("conf") branch of the data-side 1x2 bridge.
- Converts one SRAM-like uncached access (MMIO / confreg) into a single-beat AXI3 read or write transaction.
- Strictly one transaction outstanding at a time; access order is preserved by construction.
- Output sits on the data-side master port ahead of the top-level AXI arbiter.

Parameters:
- AXI_ID, 4'd1, constant ID driven on arid/awid/wid.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- conf_data_req  in  1  access request
- conf_data_wr  in  1  1 = write, 0 = read
- conf_data_size  in  2  0 = byte, 1 = half, 2 = word
- conf_data_addr  in  32  byte address
- conf_data_wdata  in  32  write data, already lane-aligned
- conf_data_rdata  out  32  read data, valid with data_ok
- conf_data_addr_ok  out  1  request accepted this cycle
- conf_data_data_ok  out  1  access complete (1-cycle pulse)
- arid  out  4  read ID (= AXI_ID)
- araddr  out  32  read address
- arlen  out  4  read burst length, fixed 0
- arsize  out  3  read beat size
- arburst  out  2  burst type, fixed 2'b01
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- rid  in  4  read ID (ignored)
- rdata  in  32  read data
- rresp  in  2  read response (ignored)
- rlast  in  1  last read beat (ignored)
- rvalid  in  1  read data valid
- rready  out  1  read data ready
- awid  out  4  write ID (= AXI_ID)
- awaddr  out  32  write address
- awlen  out  4  write burst length, fixed 0
- awsize  out  3  write beat size
- awburst  out  2  burst type, fixed 2'b01
- awvalid  out  1  write address valid
- awready  in  1  write address ready
- wid  out  4  write data ID (= AXI_ID)
- wdata  out  32  write data
- wstrb  out  4  write byte strobes
- wlast  out  1  last write beat, fixed 1
- wvalid  out  1  write data valid
- wready  in  1  write data ready
- bid  in  4  write response ID (ignored)
- bresp  in  2  write response (ignored)
- bvalid  in  1  write response valid
- bready  out  1  write response ready

Behaviour:
- FSM states: IDLE, RD_AR, RD_R, WR_AW_W, WR_B, DONE.
- Reset (resetn=0 at a clk edge):
  - State goes to IDLE.
  - arvalid, rready, awvalid, wvalid, bready and data_ok all go to 0; conf_data_rdata goes to 0.
  - Applies mid-transaction as well; the in-flight AXI transfer is abandoned, since slaves reset with the same resetn.
- conf_data_addr_ok is combinational: asserted = (state==IDLE) & conf_data_req.
- On an accept cycle, latch wr, size, addr and wdata, then:
  - wr=0: go to RD_AR.
  - wr=1: go to WR_AW_W.
- RD_AR:
  - arvalid=1; araddr and arsize={1'b0,size} come from the latch.
  - On arvalid&arready, go to RD_R.
- RD_R:
  - rready=1.
  - On rvalid, capture rdata into conf_data_rdata and go to DONE.
- WR_AW_W:
  - awvalid and wvalid are asserted independently on entry; each drops after its own handshake.
  - Leave for WR_B only when both handshakes have completed, in either order or in the same cycle.
  - wstrb by size:
    - size 0: 4'b0001 << addr[1:0]
    - size 1: 4'b0011 << addr[1:0]
    - size 2 or 3: 4'b1111
  - Size 3 is treated as a word access.
- WR_B:
  - bready=1.
  - On bvalid, go to DONE.
- DONE:
  - conf_data_data_ok=1 for exactly one cycle; go to IDLE next cycle.
  - conf_data_rdata holds its value until the next read capture.
- Minimum latency with zero-wait slaves:
  - Read: accept at cycle 0, AR at cycle 1, R at cycle 2, data_ok at cycle 3.
  - Write: data_ok at cycle 3.
- No new request is accepted from accept through DONE; req held by the CPU simply waits.
- All AXI address, size and strobe outputs are driven from the latched copy only, never from the live conf_* inputs.
- rresp/bresp are not checked.
- Misaligned half-word accesses (addr[0]=1) produce the shifted strobe; they are not flagged.

Test Plan:
- Read with zero-wait slave: req, wr=0, addr=0xBFAF_F000, size=2 → addr_ok at cycle 0; arvalid cycle 1 with araddr=0xBFAF_F000, arsize=3'b010; rvalid at cycle 2 with rdata=0x1234_5678 → data_ok at cycle 3, conf_data_rdata=0x1234_5678.
- Byte write: size=0, addr=0xBFAF_F003, wdata=0xAB00_0000 → wstrb=4'b1000, awsize=3'b000, wlast=1, wdata=0xAB00_0000; data_ok one cycle after bvalid.
- AW/W ordering: awready held low 3 cycles while wready=1 → wvalid drops after 1 cycle, awvalid stays high until its handshake; exactly one data_ok pulse.
- Back-pressure: req held high during an in-flight access → addr_ok stays 0 until IDLE; the second access starts only after the first data_ok.
- Reset mid-read: resetn low while in RD_R → next cycle arvalid=rready=0, data_ok=0, rdata=0; a fresh read after reset completes normally.
- Half write: size=1, addr low bits=2 → wstrb=4'b1100.

Source files
------------

// File: rtl/uncached_axi_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : uncached_axi_bridge_if
// Purpose  : SRAM-like uncached request side plus single-beat AXI3 master bus.
// Revision : 1.0 - initial release
// ============================================================================
interface uncached_axi_bridge_if;
  logic        conf_data_req;
  logic        conf_data_wr;
  logic [1:0]  conf_data_size;
  logic [31:0] conf_data_addr;
  logic [31:0] conf_data_wdata;
  logic [31:0] conf_data_rdata;
  logic        conf_data_addr_ok;
  logic        conf_data_data_ok;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  conf_data_req, conf_data_wr, conf_data_size, conf_data_addr, conf_data_wdata,
    output conf_data_rdata, conf_data_addr_ok, conf_data_data_ok,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output conf_data_req, conf_data_wr, conf_data_size, conf_data_addr, conf_data_wdata,
    input  conf_data_rdata, conf_data_addr_ok, conf_data_data_ok,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface
`default_nettype wire

// File: rtl/uncached_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uncached_axi_bridge
// Purpose  : Turns one SRAM-like uncached access into a single-beat AXI3 txn.
// Revision : 1.0 - initial release
// ============================================================================
module uncached_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic                  clk,
  input  logic                  resetn,
  uncached_axi_bridge_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_AR   = 3'd1,
    RD_R    = 3'd2,
    WR_AW_W = 3'd3,
    WR_B    = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        accept, ar_hs, aw_hs, w_hs;
  logic [3:0]  wstrb;
  logic        unused_inputs;

  assign accept = (state_q == IDLE) && bus.conf_data_req;
  assign ar_hs  = bus.arvalid && bus.arready;
  assign aw_hs  = bus.awvalid && bus.awready;
  assign w_hs   = bus.wvalid && bus.wready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (accept) begin
        size_q  <= bus.conf_data_size;
        addr_q  <= bus.conf_data_addr;
        wdata_q <= bus.conf_data_wdata;
      end
      if ((state_q == RD_R) && bus.rvalid) begin
        rdata_q <= bus.rdata;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = bus.conf_data_wr ? WR_AW_W : RD_AR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      RD_AR:   if (ar_hs) state_d = RD_R;
      RD_R:    if (bus.rvalid) state_d = DONE;
      WR_AW_W: begin
        // AW and W may complete in either order; leave once both have landed
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WR_B;
      end
      WR_B:    if (bus.bvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = 4'b0011 << addr_q[1:0];
      default: wstrb = 4'b1111;
    endcase
  end

  assign bus.conf_data_addr_ok = accept;
  assign bus.conf_data_data_ok = (state_q == DONE);
  assign bus.conf_data_rdata   = rdata_q;

  assign bus.arid    = AXI_ID;
  assign bus.araddr  = addr_q;
  assign bus.arlen   = 4'd0;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = 2'b01;
  assign bus.arvalid = (state_q == RD_AR);
  assign bus.rready  = (state_q == RD_R);

  assign bus.awid    = AXI_ID;
  assign bus.awaddr  = addr_q;
  assign bus.awlen   = 4'd0;
  assign bus.awsize  = {1'b0, size_q};
  assign bus.awburst = 2'b01;
  assign bus.awvalid = (state_q == WR_AW_W) && !aw_done_q;
  assign bus.wid     = AXI_ID;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb;
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = (state_q == WR_AW_W) && !w_done_q;
  assign bus.bready  = (state_q == WR_B);

  assign unused_inputs = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp};

endmodule
`default_nettype wire

// File: tb/tb_uncached_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uncached_axi_bridge
// Purpose  : Self-checking bench: vector table, random accesses, reset corner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uncached_axi_bridge;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  uncached_axi_bridge_if bus ();

  uncached_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rresp_data;
    int          ar_w, r_w, aw_w, w_w, b_w;
    logic        hold;
    logic [3:0]  exp_strb;
    int          exp_lat;
  } vec_t;

  int          total  = 0;
  int          passed = 0;
  logic [31:0] last_rdata;
  vec_t        tbl[11];

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endfunction

  // Strobe = one bit per byte touched, starting at the byte offset (words always full)
  function automatic logic [3:0] strb_model(input logic [1:0] size, input logic [31:0] addr);
    int nb, sh;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    sh = (nb == 4) ? 0 : int'(addr[1:0]);
    return 4'((((1 << nb) - 1) << sh) & 15);
  endfunction

  function automatic int lat_model(input vec_t v);
    if (!v.wr) return 3 + v.ar_w + v.r_w;
    return 3 + ((v.aw_w > v.w_w) ? v.aw_w : v.w_w) + v.b_w;
  endfunction

  task automatic slave_idle();
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'hDEAD_BEEF;
    bus.rid = 4'd0; bus.rresp = 2'd0; bus.rlast = 1'b1;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
    bus.bid = 4'd0; bus.bresp = 2'd0;
  endtask

  // Called at the start of an IDLE cycle; returns at the start of the IDLE cycle after data_ok
  task automatic run_access(input vec_t v, input logic [3:0] exp_strb, input int exp_lat);
    bit ar_d, aw_d, w_d, r_d, b_d, ok, r_pend, b_pend;
    int ar_c, aw_c, w_c, r_c, b_c, fin;
    ar_d = 0; aw_d = 0; w_d = 0; r_d = 0; b_d = 0; ok = 0;
    ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0; fin = -1;
    slave_idle();
    bus.conf_data_req   = 1'b1;
    bus.conf_data_wr    = v.wr;
    bus.conf_data_size  = v.size;
    bus.conf_data_addr  = v.addr;
    bus.conf_data_wdata = v.wdata;
    #1;
    chk("addr_ok_accept", bus.conf_data_addr_ok, 1);
    chk("data_ok_accept", bus.conf_data_data_ok, 0);
    for (int cyc = 1; cyc < 64 && !ok; cyc++) begin
      @(posedge clk); #1;
      bus.conf_data_req   = v.hold;
      bus.conf_data_wr    = ~v.wr;
      bus.conf_data_size  = ~v.size;
      bus.conf_data_addr  = ~v.addr;
      bus.conf_data_wdata = ~v.wdata;
      r_pend = ar_d && !r_d;
      b_pend = aw_d && w_d && !b_d;
      bus.arready = bus.arvalid && (ar_c >= v.ar_w);
      bus.awready = bus.awvalid && (aw_c >= v.aw_w);
      bus.wready  = bus.wvalid && (w_c >= v.w_w);
      bus.rvalid  = r_pend && (r_c >= v.r_w);
      bus.rdata   = bus.rvalid ? v.rresp_data : 32'hDEAD_BEEF;
      bus.bvalid  = b_pend && (b_c >= v.b_w);
      #1;
      chk("arvalid", bus.arvalid, !v.wr && !ar_d);
      chk("rready",  bus.rready,  !v.wr && ar_d && !r_d);
      chk("awvalid", bus.awvalid, v.wr && !aw_d);
      chk("wvalid",  bus.wvalid,  v.wr && !w_d);
      chk("bready",  bus.bready,  v.wr && aw_d && w_d && !b_d);
      chk("addr_ok_busy", bus.conf_data_addr_ok, 0);
      chk("data_ok", bus.conf_data_data_ok, (fin >= 0) && (cyc == fin + 1));
      if (bus.arvalid) begin
        chk("araddr", bus.araddr, v.addr);
        chk("arsize", bus.arsize, {1'b0, v.size});
        chk("arlen_burst_id", {bus.arlen, bus.arburst, bus.arid}, {4'd0, 2'b01, 4'd1});
      end
      if (bus.awvalid) begin
        chk("awaddr", bus.awaddr, v.addr);
        chk("awsize", bus.awsize, {1'b0, v.size});
        chk("awlen_burst_id", {bus.awlen, bus.awburst, bus.awid}, {4'd0, 2'b01, 4'd1});
      end
      if (bus.wvalid) begin
        chk("wdata", bus.wdata, v.wdata);
        chk("wstrb", bus.wstrb, exp_strb);
        chk("wlast_wid", {bus.wlast, bus.wid}, {1'b1, 4'd1});
      end
      if ((fin >= 0) && (cyc == fin + 1)) begin
        if (!v.wr) last_rdata = v.rresp_data;
        chk("rdata", bus.conf_data_rdata, last_rdata);
        chk("latency", cyc, exp_lat);
        ok = 1;
      end
      if (bus.arvalid && bus.arready) ar_d = 1; else if (bus.arvalid) ar_c++;
      if (bus.awvalid && bus.awready) aw_d = 1; else if (bus.awvalid) aw_c++;
      if (bus.wvalid && bus.wready) w_d = 1; else if (bus.wvalid) w_c++;
      if (bus.rvalid && bus.rready) begin r_d = 1; fin = cyc; end else if (r_pend) r_c++;
      if (bus.bvalid && bus.bready) begin b_d = 1; fin = cyc; end else if (b_pend) b_c++;
    end
    chk("complete", ok, 1);
    @(posedge clk); #1;
    slave_idle();
    chk("data_ok_after", bus.conf_data_data_ok, 0);
    if (!v.hold) begin
      bus.conf_data_req = 1'b0;
      #1;
      chk("addr_ok_idle_noreq", bus.conf_data_addr_ok, 0);
    end
  endtask

  initial begin
    vec_t v;
    //        wr    size   addr            wdata          rresp_data     arw rw aww ww bw hold  strb      lat
    tbl[0]  = '{1'b0, 2'd2, 32'hBFAF_F000, 32'h0,         32'h1234_5678, 0, 0, 0, 0, 0, 1'b0, 4'b1111, 3};
    tbl[1]  = '{1'b1, 2'd0, 32'hBFAF_F003, 32'hAB00_0000, 32'h0,         0, 0, 0, 0, 0, 1'b0, 4'b1000, 3};
    tbl[2]  = '{1'b1, 2'd2, 32'hBFAF_F010, 32'hCAFE_F00D, 32'h0,         0, 0, 3, 0, 0, 1'b0, 4'b1111, 6};
    tbl[3]  = '{1'b1, 2'd1, 32'hBFAF_F002, 32'h55AA_0000, 32'h0,         0, 0, 0, 0, 0, 1'b1, 4'b1100, 3};
    tbl[4]  = '{1'b0, 2'd2, 32'h1FD0_0004, 32'h0,         32'hA5A5_0F0F, 2, 1, 0, 0, 0, 1'b0, 4'b1111, 6};
    tbl[5]  = '{1'b1, 2'd3, 32'h1FD0_0009, 32'h0102_0304, 32'h0,         0, 0, 0, 2, 1, 1'b0, 4'b1111, 6};
    tbl[6]  = '{1'b1, 2'd1, 32'h1FD0_0003, 32'h7700_0000, 32'h0,         0, 0, 0, 0, 2, 1'b0, 4'b1000, 5};
    tbl[7]  = '{1'b1, 2'd1, 32'h1FD0_0001, 32'h0033_4400, 32'h0,         0, 0, 0, 0, 0, 1'b0, 4'b0110, 3};
    tbl[8]  = '{1'b0, 2'd0, 32'h1FD0_0002, 32'h0,         32'h00EE_0000, 0, 0, 0, 0, 0, 1'b0, 4'b0100, 3};
    tbl[9]  = '{1'b1, 2'd0, 32'h1FD0_0000, 32'h0000_0099, 32'h0,         0, 0, 1, 1, 0, 1'b0, 4'b0001, 4};
    tbl[10] = '{1'b0, 2'd2, 32'h1FD0_0010, 32'h0,         32'h8765_4321, 0, 3, 0, 0, 0, 1'b0, 4'b1111, 6};

    resetn = 1'b0;
    slave_idle();
    bus.conf_data_req = 1'b0; bus.conf_data_wr = 1'b0; bus.conf_data_size = 2'd0;
    bus.conf_data_addr = 32'd0; bus.conf_data_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 0);
    chk("rst_data_ok", bus.conf_data_data_ok, 0);
    chk("rst_rdata", bus.conf_data_rdata, 0);
    resetn = 1'b1;
    last_rdata = 32'd0;

    for (int i = 0; i < 11; i++) run_access(tbl[i], tbl[i].exp_strb, tbl[i].exp_lat);

    // Reset while waiting in the read-data phase
    bus.conf_data_req = 1'b1; bus.conf_data_wr = 1'b0; bus.conf_data_size = 2'd2;
    bus.conf_data_addr = 32'h1FD0_0020;
    @(posedge clk); #1;
    bus.conf_data_req = 1'b0; bus.arready = 1'b1;
    #1; chk("mr_arvalid", bus.arvalid, 1);
    @(posedge clk); #1;
    bus.arready = 1'b0;
    #1; chk("mr_rready", bus.rready, 1);
    chk("mr_rdata_before", bus.conf_data_rdata, last_rdata);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    #1;
    chk("mr_ar_r", {bus.arvalid, bus.rready}, 0);
    chk("mr_data_ok", bus.conf_data_data_ok, 0);
    chk("mr_rdata", bus.conf_data_rdata, 0);
    last_rdata = 32'd0;
    v = '{1'b0, 2'd2, 32'h1FD0_0024, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 1'b0, 4'b1111, 3};
    run_access(v, v.exp_strb, v.exp_lat);

    for (int i = 0; i < 40; i++) begin
      v.wr         = 1'($urandom_range(0, 1));
      v.size       = 2'($urandom_range(0, 3));
      v.addr       = $urandom;
      v.wdata      = $urandom;
      v.rresp_data = $urandom;
      v.ar_w = $urandom_range(0, 3); v.r_w = $urandom_range(0, 3);
      v.aw_w = $urandom_range(0, 3); v.w_w = $urandom_range(0, 3);
      v.b_w  = $urandom_range(0, 3);
      v.hold = 1'($urandom_range(0, 1));
      run_access(v, strb_model(v.size, v.addr), lat_model(v));
    end
    bus.conf_data_req = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
